lcd_fb_addr_ctrl: RTL and testbench
===================================

# lcd_fb_addr_ctrl

Sequences pixel traffic from the LCD bus receiver into the frame buffer. The block consumes the receiver's command, parameter and RGB565 latch strobes, and implements the CASET (0x2A), PASET (0x2B), RAMWR (0x2C) and SWRESET (0x01) window semantics. It generates linear frame-buffer write addresses with column/page wrap and presents one pixel at a time on a valid/ready write port. It sits between the receiver and the frame-buffer write arbiter.

## Interface
- H_RES, 320, frame-buffer width in pixels
- V_RES, 240, frame-buffer height in pixels
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_lcd_rst_n  in  1  LCD-side reset, synchronous, active-low; same effect as i_rst_n
- i_command  in  8  last latched command byte
- i_command_latch  in  1  1-cycle strobe: i_command updated
- i_param  in  8  last latched parameter byte
- i_param_latch  in  1  1-cycle strobe: i_param updated
- i_rgb565  in  16  last latched pixel
- i_rgb565_latch  in  1  1-cycle strobe: i_rgb565 updated
- o_fb_valid  out  1  pixel write pending
- i_fb_ready  in  1  frame-buffer write accepted when high with o_fb_valid
- o_fb_addr  out  ADDR_W  write address, y*H_RES + x
- o_fb_data  out  16  RGB565 pixel
- o_overflow  out  1  sticky: pixel dropped because the write port was stalled

## Operation
- Reset (either reset low) values:
  - XS=0, XE=H_RES-1, YS=0, YE=V_RES-1, x=0, y=0, row_base=0, ys_base=0
  - param_idx=0, cur_cmd=0x00
  - o_fb_valid=0, o_fb_addr=0, o_fb_data=0, o_overflow=0
- i_command_latch: cur_cmd<=i_command and param_idx<=0. Any partial CASET/PASET parameter sequence is discarded.
  - 0x2C: x<=XS, y<=YS, row_base<=ys_base.
  - 0x01: window, counters and o_overflow return to their reset values. A pending o_fb_valid is kept.
- i_param_latch with cur_cmd 0x2A or 0x2B and param_idx<4: shift the byte into a 32-bit shadow and increment param_idx.
  - Parameter order: start[15:8], start[7:0], end[15:8], end[7:0].
  - On the 4th byte, commit the shadow if start≤end; otherwise ignore the commit and leave the window unchanged.
  - A PASET commit also sets ys_base<=start*H_RES, truncated to ADDR_W.
  - Parameters beyond the 4th, and parameters for any other command, are ignored.
- i_rgb565_latch, per pixel:
  - Emit the pixel only if x<H_RES and y<V_RES; out-of-range pixels are silently dropped.
  - The counters advance whether the pixel is emitted or dropped:
    - x==XE: x<=XS and row_base+=H_RES, y++.
    - Additionally, if y==YE: y<=YS and row_base<=ys_base.
    - Otherwise: x++.
- Address: o_fb_addr = row_base + x, using the pre-advance values. row_base is a running sum; the datapath contains no per-pixel multiplier.
- Simultaneous i_command_latch and i_param_latch: the command wins and the parameter is ignored. The receiver never produces this case.

## Timing
- Pixel latency: i_rgb565_latch in cycle N gives o_fb_valid=1 with o_fb_addr/o_fb_data in cycle N+1.
- o_fb_valid, o_fb_addr and o_fb_data stay stable until the cycle with o_fb_valid & i_fb_ready. o_fb_valid then drops in the next cycle unless a new pixel loads.
- The holding register is one entry. A new emitted pixel in a cycle where o_fb_valid & ~i_fb_ready holds:
  - the new pixel is dropped;
  - o_overflow<=1;
  - the counters still advance.
- A new pixel in the cycle where o_fb_valid & i_fb_ready holds loads with no bubble.
- Window registers update in the cycle after the 4th parameter strobe.
- ys_base may be computed over at most 2 cycles: receiver strobes are spaced ≥2 cycles apart.
- A reset mid-operation takes effect in the next cycle. Any pending write is abandoned: o_fb_valid=0.

## Structure
- Shared package lcd_pkg:
  - CMD_SWRESET=8'h01, CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C
  - a window struct {xs, xe, ys, ye}, each 16 bits
- One sub-module, lcd_win_counter: holds x, y and row_base, with wrap logic and start/advance inputs.
- The top level holds the command/parameter decoder and the write holding register.

## Test plan
- Reset, then 0x2C and 3 pixels 0x1111/0x2222/0x3333 with i_fb_ready=1 -> writes at addr 0, 1, 2, each valid 1 cycle after its latch.
- CASET 0,10,0,12 and PASET 0,5,0,6, then 0x2C and 6 pixels -> addrs 1610, 1611, 1612, 1930, 1931, 1932, then wrap back to 1610.
- CASET 0x01,0x3F,0x01,0x40 (x=319..320), then 0x2C and 2 pixels -> only addr 319 written; the x=320 pixel is dropped and o_overflow stays 0.
- i_fb_ready=0, two pixels -> first held stable, second dropped, o_overflow=1. After ready, the next pixel lands at the counter position after both.
- CASET with start 20 > end 10 -> window unchanged. CASET interrupted after 2 parameters by 0x2C -> window unchanged, x=XS.
- Mid-stream, i_lcd_rst_n low for 1 cycle -> o_fb_valid=0 and full-screen window. The next 0x2C pixel goes to addr 0.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | lcd_pkg: LCD controller command codes and window type                 |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package lcd_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef struct packed {
    logic [15:0] xs;
    logic [15:0] xe;
    logic [15:0] ys;
    logic [15:0] ye;
  } win_t;

  function automatic win_t win_reset(input int unsigned h, input int unsigned v);
    win_t w;
    w.xs = '0;
    w.xe = 16'(h - 1);
    w.ys = '0;
    w.ye = 16'(v - 1);
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_win_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | lcd_win_counter: column/page counters with window wrap and row base   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module lcd_win_counter
  import lcd_pkg::*;
#(
  parameter int H_RES  = 320,
  parameter int ADDR_W = 17
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_start,
  input  logic              i_advance,
  input  win_t              i_win,
  input  logic [ADDR_W-1:0] i_ys_base,
  output logic [15:0]       o_x,
  output logic [15:0]       o_y,
  output logic [ADDR_W-1:0] o_row_base
);

  logic [15:0]       x_q, x_d;
  logic [15:0]       y_q, y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;

  // row_base tracks y*H_RES incrementally so no per-pixel multiply is needed
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    if (i_clear) begin
      x_d        = '0;
      y_d        = '0;
      row_base_d = '0;
    end else if (i_start) begin
      x_d        = i_win.xs;
      y_d        = i_win.ys;
      row_base_d = i_ys_base;
    end else if (i_advance) begin
      if (x_q == i_win.xe) begin
        x_d = i_win.xs;
        if (y_q == i_win.ye) begin
          y_d        = i_win.ys;
          row_base_d = i_ys_base;
        end else begin
          y_d        = y_q + 16'd1;
          row_base_d = row_base_q + ADDR_W'(H_RES);
        end
      end else begin
        x_d = x_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
    end
  end

  assign o_x        = x_q;
  assign o_y        = y_q;
  assign o_row_base = row_base_q;

endmodule
`default_nettype wire

// File: rtl/lcd_fb_addr_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | lcd_fb_addr_ctrl: command/parameter decode and frame-buffer writer    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module lcd_fb_addr_ctrl
  import lcd_pkg::*;
#(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lcd_rst_n,
  input  logic [7:0]        i_command,
  input  logic              i_command_latch,
  input  logic [7:0]        i_param,
  input  logic              i_param_latch,
  input  logic [15:0]       i_rgb565,
  input  logic              i_rgb565_latch,
  output logic              o_fb_valid,
  input  logic              i_fb_ready,
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic [15:0]       o_fb_data,
  output logic              o_overflow
);

  logic w_rst_n;
  assign w_rst_n = i_rst_n & i_lcd_rst_n;

  logic [7:0]        cur_cmd_q, cur_cmd_d;
  logic [2:0]        param_idx_q, param_idx_d;
  logic [23:0]       shadow_q, shadow_d;
  win_t              win_q, win_d;
  logic [ADDR_W-1:0] ys_base_q, ys_base_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              ovf_q, ovf_d;

  logic              w_start, w_clear, w_emit;
  logic [31:0]       w_param_full;
  logic [15:0]       w_pstart, w_pend;
  logic [15:0]       w_x, w_y;
  logic [ADDR_W-1:0] w_row_base;

  assign w_param_full = {shadow_q, i_param};
  assign w_pstart     = w_param_full[31:16];
  assign w_pend       = w_param_full[15:0];
  assign w_emit       = i_rgb565_latch && (w_x < 16'(H_RES)) && (w_y < 16'(V_RES));

  always_comb begin
    cur_cmd_d   = cur_cmd_q;
    param_idx_d = param_idx_q;
    shadow_d    = shadow_q;
    win_d       = win_q;
    ys_base_d   = ys_base_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    data_d      = data_q;
    ovf_d       = ovf_q;
    w_start     = 1'b0;
    w_clear     = 1'b0;

    if (i_command_latch) begin
      cur_cmd_d   = i_command;
      param_idx_d = '0;
      if (i_command == CMD_RAMWR) begin
        w_start = 1'b1;
      end
      // soft reset keeps any pending write so the arbiter handshake is not broken
      if (i_command == CMD_SWRESET) begin
        w_clear   = 1'b1;
        win_d     = win_reset(H_RES, V_RES);
        ys_base_d = '0;
        ovf_d     = 1'b0;
      end
    end else if (i_param_latch && ((cur_cmd_q == CMD_CASET) || (cur_cmd_q == CMD_PASET))
                 && (param_idx_q < 3'd4)) begin
      shadow_d    = w_param_full[23:0];
      param_idx_d = param_idx_q + 3'd1;
      if ((param_idx_q == 3'd3) && (w_pstart <= w_pend)) begin
        if (cur_cmd_q == CMD_CASET) begin
          win_d.xs = w_pstart;
          win_d.xe = w_pend;
        end else begin
          win_d.ys  = w_pstart;
          win_d.ye  = w_pend;
          ys_base_d = ADDR_W'(w_pstart) * ADDR_W'(H_RES);
        end
      end
    end

    if (valid_q && !i_fb_ready) begin
      if (w_emit) begin
        ovf_d = 1'b1;
      end
    end else if (w_emit) begin
      valid_d = 1'b1;
      addr_d  = w_row_base + ADDR_W'(w_x);
      data_d  = i_rgb565;
    end else if (valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!w_rst_n) begin
      cur_cmd_q   <= 8'h00;
      param_idx_q <= '0;
      shadow_q    <= '0;
      win_q       <= win_reset(H_RES, V_RES);
      ys_base_q   <= '0;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      cur_cmd_q   <= cur_cmd_d;
      param_idx_q <= param_idx_d;
      shadow_q    <= shadow_d;
      win_q       <= win_d;
      ys_base_q   <= ys_base_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
    end
  end

  lcd_win_counter #(
    .H_RES  (H_RES),
    .ADDR_W (ADDR_W)
  ) u_win_counter (
    .i_clk      (i_clk),
    .i_rst_n    (w_rst_n),
    .i_clear    (w_clear),
    .i_start    (w_start),
    .i_advance  (i_rgb565_latch),
    .i_win      (win_q),
    .i_ys_base  (ys_base_q),
    .o_x        (w_x),
    .o_y        (w_y),
    .o_row_base (w_row_base)
  );

  assign o_fb_valid = valid_q;
  assign o_fb_addr  = addr_q;
  assign o_fb_data  = data_q;
  assign o_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_fb_addr_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_lcd_fb_addr_ctrl: randomized scoreboard bench for lcd_fb_addr_ctrl |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_lcd_fb_addr_ctrl;

  localparam int H_RES  = 320;
  localparam int V_RES  = 240;
  localparam int ADDR_W = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0, lcd_rst_n = 1'b1;
  logic [7:0]        cmd = '0, par = '0;
  logic              cmd_l = 1'b0, par_l = 1'b0, pix_l = 1'b0, ready = 1'b1;
  logic [15:0]       pix = '0;
  logic              valid, ovf;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       data;

  lcd_fb_addr_ctrl #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_lcd_rst_n     (lcd_rst_n),
    .i_command       (cmd),
    .i_command_latch (cmd_l),
    .i_param         (par),
    .i_param_latch   (par_l),
    .i_rgb565        (pix),
    .i_rgb565_latch  (pix_l),
    .o_fb_valid      (valid),
    .i_fb_ready      (ready),
    .o_fb_addr       (addr),
    .o_fb_data       (data),
    .o_overflow      (ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: window, pixel position, pending slot, expected writes
  int   m_xs, m_xe, m_ys, m_ye, m_x, m_y, m_pidx;
  int   m_sh[4];
  logic [7:0] m_cmd;
  bit   m_pend, m_ovf;
  typedef struct { int addr; int data; } wr_t;
  wr_t  sbq[$];
  bit   mon_en = 1'b0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_xs = 0; m_xe = H_RES - 1; m_ys = 0; m_ye = V_RES - 1;
    m_x = 0; m_y = 0; m_pidx = 0; m_cmd = 8'h00;
    m_pend = 1'b0; m_ovf = 1'b0;
    sbq.delete();
  endtask

  // applies the rules to the inputs the DUT sampled at the posedge just passed
  task automatic model_step();
    bit pushed;
    int s, e;
    pushed = 1'b0;
    if (!rst_n || !lcd_rst_n) begin
      model_reset();
      return;
    end
    if (cmd_l) begin
      m_cmd = cmd; m_pidx = 0;
      if (cmd == 8'h2C) begin m_x = m_xs; m_y = m_ys; end
      if (cmd == 8'h01) begin
        m_xs = 0; m_xe = H_RES - 1; m_ys = 0; m_ye = V_RES - 1;
        m_x = 0; m_y = 0; m_ovf = 1'b0;
      end
    end else if (par_l && (m_cmd == 8'h2A || m_cmd == 8'h2B) && m_pidx < 4) begin
      m_sh[m_pidx] = int'(par);
      m_pidx++;
      if (m_pidx == 4) begin
        s = m_sh[0] * 256 + m_sh[1];
        e = m_sh[2] * 256 + m_sh[3];
        if (s <= e) begin
          if (m_cmd == 8'h2A) begin m_xs = s; m_xe = e; end
          else begin m_ys = s; m_ye = e; end
        end
      end
    end
    if (pix_l) begin
      if (m_x < H_RES && m_y < V_RES) begin
        if (m_pend && !ready) m_ovf = 1'b1;
        else begin
          sbq.push_back('{(m_y * H_RES + m_x) % (1 << ADDR_W), int'(pix)});
          m_pend = 1'b1;
          pushed = 1'b1;
        end
      end
      if (m_x == m_xe) begin
        m_x = m_xs;
        if (m_y == m_ye) m_y = m_ys;
        else m_y = (m_y + 1) & 16'hFFFF;
      end else begin
        m_x = (m_x + 1) & 16'hFFFF;
      end
    end
    if (!pushed && m_pend && ready) m_pend = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("valid", {31'd0, valid}, {31'd0, m_pend});
      check("overflow", {31'd0, ovf}, {31'd0, m_ovf});
      if (valid === 1'b1) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d, expected no write (t=%0t)", addr, $time);
        end else begin
          check("addr", 32'(addr), sbq[0].addr);
          check("data", 32'(data), sbq[0].data);
          if (ready) void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cmd_l = 1'b0; par_l = 1'b0; pix_l = 1'b0;
    if (rand_ready) ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd = c; cmd_l = 1'b1; step(); step();
  endtask

  task automatic send_par(input logic [7:0] p);
    par = p; par_l = 1'b1; step(); step();
  endtask

  task automatic send_pix(input logic [15:0] p);
    pix = p; pix_l = 1'b1; step(); step();
  endtask

  task automatic set_win(input bit page, input int s, input int e);
    send_cmd(page ? 8'h2B : 8'h2A);
    send_par(8'(s >> 8)); send_par(8'(s));
    send_par(8'(e >> 8)); send_par(8'(e));
  endtask

  initial begin
    model_reset();
    step();
    mon_en = 1'b1;
    step();
    @(negedge clk);
    check("reset_addr", 32'(addr), 0);
    check("reset_data", 32'(data), 0);
    check("reset_valid", {31'd0, valid}, 0);
    check("reset_ovf", {31'd0, ovf}, 0);
    rst_n = 1'b1;
    step();

    // full-screen stream
    send_cmd(8'h2C);
    send_pix(16'h1111); send_pix(16'h2222); send_pix(16'h3333);

    // small window with column and page wrap
    set_win(1'b0, 10, 12);
    set_win(1'b1, 5, 6);
    send_cmd(8'h2C);
    for (int i = 0; i < 7; i++) send_pix(16'(16'h0100 + i));

    // window straddling the right edge
    send_cmd(8'h01);
    set_win(1'b0, 319, 320);
    send_cmd(8'h2C);
    send_pix(16'hAAAA); send_pix(16'hBBBB);

    // stall: hold, drop, then resume past both
    send_cmd(8'h01);
    send_cmd(8'h2C);
    ready = 1'b0;
    send_pix(16'h4444); send_pix(16'h5555);
    ready = 1'b1;
    step();
    send_pix(16'h6666);

    // reversed and interrupted window programming
    set_win(1'b0, 20, 10);
    send_cmd(8'h2A); send_par(8'h00); send_par(8'h05);
    send_cmd(8'h2C);
    send_pix(16'h7777);

    // LCD reset mid-stream abandons the pending write
    set_win(1'b0, 30, 40);
    set_win(1'b1, 7, 9);
    send_cmd(8'h2C);
    ready = 1'b0;
    send_pix(16'h8888);
    lcd_rst_n = 1'b0; step();
    lcd_rst_n = 1'b1; step();
    ready = 1'b1;
    send_cmd(8'h2C);
    send_pix(16'h9999);

    // randomized traffic
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: set_win(1'b0, $urandom_range(0, 340), $urandom_range(0, 340));
        1: set_win(1'b1, $urandom_range(0, 260), $urandom_range(0, 260));
        2: send_cmd(8'h2C);
        3: if ($urandom_range(0, 3) == 0) send_cmd(8'h01); else send_cmd(8'h2C);
        4: send_par(8'($urandom));
        5: begin
          send_cmd(8'h2A + 8'($urandom_range(0, 1)));
          send_par(8'($urandom_range(0, 1)));
        end
        default: begin
          int n;
          n = $urandom_range(1, 8);
          for (int k = 0; k < n; k++) send_pix(16'($urandom));
        end
      endcase
    end

    rand_ready = 1'b0;
    ready = 1'b1;
    repeat (4) step();
    check("scoreboard_empty", 32'(sbq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
